// File: rtl/bin2qdi_1of2.sv
// rtl/bin2qdi_1of2.sv - clocked binary to 1-of-2 QDI token sender with four-phase RTZ handshake
// Optional macro BIN2QDI_PROTOCOL_CHECK_EN adds the sticky ERR output for stray acknowledges.
module bin2qdi_1of2 #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    inout  wire        VDD,
    inout  wire        VSS,
    output logic [1:0] R,
    input  logic       D,
    input  logic       GO,
    input  logic       E
`ifdef BIN2QDI_PROTOCOL_CHECK_EN
    ,
    output logic       ERR
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_RTZ  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [1:0]             r_state;
    logic [1:0]             r_rail;
    logic                   w_es;

    // Synchronizer resets to "receiver ready" so a token can launch right after reset.
    generate
        if (SYNC_STAGES == 1) begin : g_sync1
            always_ff @(posedge CLK) begin
                if (RESET) r_sync <= '1;
                else       r_sync <= E;
            end
        end else begin : g_syncn
            always_ff @(posedge CLK) begin
                if (RESET) r_sync <= '1;
                else       r_sync <= {r_sync[SYNC_STAGES-2:0], E};
            end
        end
    endgenerate

    assign w_es = r_sync[SYNC_STAGES-1];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_rail  <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (GO && w_es) begin
                        r_rail  <= {D, ~D};
                        r_state <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (!w_es) begin
                        r_rail  <= 2'b00;
                        r_state <= S_RTZ;
                    end
                end
                S_RTZ: begin
                    if (w_es) r_state <= GO ? S_DONE : S_IDLE;
                end
                default: begin
                    // DONE: hold off until GO drops so one GO high period yields one token
                    if (!GO) r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign R = r_rail;

`ifdef BIN2QDI_PROTOCOL_CHECK_EN
    logic r_es_q;
    logic r_err;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_es_q <= 1'b1;
            r_err  <= 1'b0;
        end else begin
            r_es_q <= w_es;
            if (r_es_q && !w_es && (r_state != S_SEND)) begin
                r_err <= 1'b1;
`ifndef SYNTHESIS
                $display("bin2qdi_1of2: warning: acknowledge with no token outstanding at %0t", $time);
`endif
            end
        end
    end

    assign ERR = r_err;
`endif

endmodule

// File: tb/tb_bin2qdi_1of2.sv
// tb/tb_bin2qdi_1of2.sv - randomized bench for bin2qdi_1of2 against a token-level reference model
module tb_bin2qdi_1of2;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       go  = 1'b0;
    logic       d   = 1'b0;
    logic       e   = 1'b1;
    logic [1:0] r;
    wire        vdd = 1'b1;
    wire        vss = 1'b0;
`ifdef BIN2QDI_PROTOCOL_CHECK_EN
    logic       err;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    bin2qdi_1of2 #(.SYNC_STAGES(S)) dut (
        .CLK  (clk),
        .RESET(rst),
        .VDD  (vdd),
        .VSS  (vss),
        .R    (r),
        .D    (d),
        .GO   (go),
        .E    (e)
`ifdef BIN2QDI_PROTOCOL_CHECK_EN
        ,
        .ERR  (err)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: token = -1 when none outstanding, else the data bit being sent.
    bit hist [S];
    int m_tok     = -1;
    bit m_wait    = 0;
    bit m_armed   = 1;
    bit m_valid   = 0;
    bit m_err     = 0;
    bit m_es_prev = 1;

    function automatic logic [1:0] model_r();
        if (m_tok < 0) return 2'b00;
        return (m_tok == 1) ? 2'b10 : 2'b01;
    endfunction

    always @(posedge clk) begin
        bit es;
        if (rst) begin
            for (int i = 0; i < S; i++) hist[i] = 1'b1;
            m_tok = -1; m_wait = 0; m_armed = 1; m_valid = 1;
            m_err = 0; m_es_prev = 1;
        end else begin
            es = hist[S-1];
            if (m_es_prev && !es && m_tok < 0) m_err = 1;
            m_es_prev = es;
            if (m_tok >= 0) begin
                if (!es) begin m_tok = -1; m_wait = 1; end
            end else if (m_wait) begin
                if (es) begin m_wait = 0; m_armed = !go; end
            end else if (!m_armed) begin
                if (!go) m_armed = 1;
            end else if (go && es) begin
                m_tok = d ? 1 : 0;
                m_armed = 0;
            end
            for (int i = S - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = e;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            n_cmp++;
            if (r !== model_r() || r === 2'b11) begin
                n_bad++;
                $display("FAIL cycle_r at %0t: R=%b required %b", $time, r, model_r());
            end
`ifdef BIN2QDI_PROTOCOL_CHECK_EN
            n_cmp++;
            if (err !== m_err) begin
                n_bad++;
                $display("FAIL cycle_err at %0t: ERR=%b required %b", $time, err, m_err);
            end
`endif
        end
    end

    task automatic step(input logic t_rst, input logic t_go, input logic t_d, input logic t_e);
        rst = t_rst; go = t_go; d = t_d; e = t_e;
        @(posedge clk);
        #2;
    endtask

    task automatic check_lit(input string name, input logic [1:0] exp);
        n_cmp++;
        if (r !== exp) begin
            n_bad++;
            $display("FAIL %s: R=%b required %b", name, r, exp);
        end
        n_cmp++;
        if (model_r() !== exp) begin
            n_bad++;
            $display("FAIL %s_model: model R=%b required %b", name, model_r(), exp);
        end
    endtask

    initial begin
        // Reset with a pending request: no token until reset is released
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 1, 1);
            check_lit("reset_hold", 2'b00);
        end
        step(0, 1, 1, 1);
        check_lit("first_token", 2'b10);

        // Read token with GO held through a full E cycle: ack latency S+1 edges
        for (int i = 0; i < S; i++) begin
            step(0, 1, 1, 0);
            check_lit("ack_latency_hold", 2'b10);
        end
        step(0, 1, 1, 0);
        check_lit("ack_neutral", 2'b00);
        for (int i = 0; i < S + 3; i++) begin
            step(0, 1, 1, 1);
            check_lit("go_held_no_retoken", 2'b00);
        end
        step(0, 0, 1, 1);
        check_lit("go_low_idle", 2'b00);

        // Write token, D toggled during SEND must not alter R
        step(0, 1, 0, 1);
        check_lit("write_token", 2'b01);
        step(0, 1, 1, 1);
        check_lit("data_stable", 2'b01);
        for (int i = 0; i < S + 1; i++) step(0, 0, 1, 0);
        check_lit("write_ack", 2'b00);
        for (int i = 0; i < S + 2; i++) begin
            step(0, 0, 0, 1);
            check_lit("write_idle", 2'b00);
        end

        // GO rises while receiver not ready: wait for E
        for (int i = 0; i < S + 1; i++) begin
            step(0, 0, 0, 0);
        end
        step(0, 1, 1, 0);
        check_lit("go_while_busy", 2'b00);
        for (int i = 0; i < S; i++) step(0, 1, 1, 1);
        step(0, 1, 1, 1);
        check_lit("go_after_ready", 2'b10);

        // Reset mid-token, then relaunch
        step(1, 0, 0, 1);
        check_lit("reset_clear", 2'b00);
        step(0, 1, 0, 1);
        check_lit("relaunch_write", 2'b01);
        step(1, 1, 0, 1);
        check_lit("reset_mid_token", 2'b00);
        step(0, 1, 1, 1);
        check_lit("after_reset_token", 2'b10);

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            logic n_go, n_e, n_rst;
            n_go  = ($urandom_range(0, 4) == 0) ? ~go : go;
            n_e   = ($urandom_range(0, 3) == 0) ? ~e : e;
            n_rst = ($urandom_range(0, 299) == 0);
            step(n_rst, n_go, 1'($urandom_range(0, 1)), n_e);
        end

        step(0, 0, 0, 1);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bin2qdi_1of2.md
Name: bin2qdi_1of2

Overview:
Clocked binary-to-QDI converter. It turns one binary bit into a 1-of-2 (dual-rail) token and sends it under a four-phase return-to-zero handshake driven by the receiver's active-high enable. It sits between synchronous test or control logic and asynchronous QDI datapaths, for example the read/write select channel of an SRAM bank. One token is sent per GO assertion.

Parameters:
SYNC_STAGES, 2, number of flops synchronizing the asynchronous enable input E (legal 1..3).

Ports:
CLK  input  1  clock; all state changes on rising edge.
RESET  input  1  synchronous, active-high reset.
VDD  inout  1  supply pin, pass-through for netlist compatibility; no logic function.
VSS  inout  1  ground pin, pass-through; no logic function.
R  output  2  dual-rail token; R[0] = rail for data 0, R[1] = rail for data 1; 2'b00 = neutral.
D  input  1  binary data bit to encode.
GO  input  1  send request; level-sensitive, one token per high period.
E  input  1  receiver enable/acknowledge; 1 = ready or neutral-acknowledged, 0 = token acknowledged.

Behaviour:
- E passes through a SYNC_STAGES flop chain. Es denotes the synchronized value. All decisions use Es.
- R is driven straight from flops, so it is glitch-free. It is never 2'b11.
- Reset: if RESET=1 at an edge, R<=2'b00, state<=IDLE, latched bit<=0 and the sync chain<=1. Reset overrides all other conditions, including mid-token.
- State IDLE (R=00):
  - If GO=1 and Es=1: latch D, set R<={D,~D}, go to SEND.
  - Otherwise stay in IDLE.
- State SEND (R holds the token):
  - If Es=0 (acknowledge): R<=00, go to RTZ.
  - D changes during SEND are ignored.
  - GO falling during SEND does not cancel the token.
- State RTZ (R=00): wait for Es=1 (receiver neutral).
  - If GO=0: go to IDLE.
  - If GO=1: go to DONE.
- State DONE (R=00): wait for GO=0, then go to IDLE. This prevents a second token from one GO pulse.
- Timing:
  - The edge that samples GO=1 with Es=1 produces a valid R after that edge.
  - Acknowledge-to-neutral latency is SYNC_STAGES+1 cycles after E falls.
- Simultaneous events:
  - GO rises while Es=0 in IDLE: no token until Es=1.
  - In RTZ, Es=1 and GO=0 in the same cycle: go directly to IDLE.
- Back-to-back tokens need GO low for at least one sampled edge between them.

Optional Feature:
Macro BIN2QDI_PROTOCOL_CHECK_EN.
- When defined, the block adds output port ERR (1 bit, registered, sticky) and a matching simulation $display warning.
- ERR sets to 1 on a falling edge of Es observed in any state other than SEND, i.e. an acknowledge with no token outstanding.
- ERR is cleared only by RESET.
- When not defined, there is no ERR port and no checking logic; behaviour is otherwise identical.

Test Plan:
- Reset: hold RESET=1 for 3 cycles with GO=1, D=1, E=1. Required: R=00 throughout. First token R=10 appears only after RESET=0.
- Write handshake:
  - Stimulus: D=0, GO=1, E=1.
  - Required: R=01 one edge later.
  - Drive E=0: R=00 within SYNC_STAGES+1 cycles.
  - Drop GO, raise E: state returns to IDLE and R stays 00.
- Read token with GO held high:
  - Stimulus: D=1, GO=1 held through a full E 1→0→1 cycle.
  - Required: exactly one R=10 token, then R=00 stays neutral until GO drops and rises again.
- Data stability: D=1, launch token R=10, toggle D to 0 during SEND. Required: R stays 10 until acknowledge.
- Reset mid-token: launch R=01, then assert RESET before E falls. Required: R=00 after that edge, state IDLE. With E=1 and GO=1 after RESET=0, a new token launches.
- Protocol check (with BIN2QDI_PROTOCOL_CHECK_EN): in IDLE, pulse E 1→0 with GO=0. Required: ERR=1 and it stays 1 until RESET. A normal handshake leaves ERR=0.
